// File: rtl/rom_sweep_reader.sv
// Walks a wrapping range of ROM addresses and streams each word out on a
// valid/ready interface with a last flag, pulsing done when the range is exhausted.
module rom_sweep_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0]   REM_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = REM_ONE[ADDR_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;

  // Next-state logic: IDLE samples the command, RUN loads words as the output slot frees up.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != REM_ZERO) begin
            addr_d  = base_addr;
            rem_d   = len;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((rem_q != REM_ZERO) && (!valid_q || out_ready)) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          last_d  = (rem_q == REM_ONE);
          addr_d  = addr_q + ADDR_ONE;
          rem_d   = rem_q - REM_ONE;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
        // Handshake on the final beat ends the sweep; nothing is left to load then.
        if (valid_q && out_ready && last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= ADDR_ZERO;
      rem_q   <= REM_ZERO;
      data_q  <= DATA_ZERO;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_rom_sweep_reader.sv
// Randomized bench for rom_sweep_reader: expected beats come from the sweep
// definition (word i of a sweep is rom[(base+i) mod 8]) rather than from the RTL.
module tb_rom_sweep_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] len;
  logic [2:0] rom_addr;
  logic [1:0] rom_data;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  int total;
  int bad;
  int exp_addr;
  logic [1:0] rom_mem [8];

  rom_sweep_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: random ready, 1: ready always high, 2: stall 3 cycles on the second beat.
  // Called and returns at a falling edge; a start here lands on a done cycle if one is up.
  task automatic run_sweep(input int b, input int l, input int mode, input bit mid_start);
    int idx;
    int cyc;
    int stall;
    int exp_word;
    check_eq("idle_addr", 32'(rom_addr), 32'(exp_addr));
    check_eq("idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    base_addr = 3'(b);
    len = 4'(l);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = 3'($urandom_range(0, 7));
    len = 4'($urandom_range(0, 8));
    if (l == 0) begin
      check_eq("len0_done", 32'(done), 32'd1);
      check_eq("len0_valid", 32'(out_valid), 32'd0);
      check_eq("len0_busy", 32'(busy), 32'd0);
      check_eq("len0_addr", 32'(rom_addr), 32'(exp_addr));
      return;
    end
    check_eq("run_busy", 32'(busy), 32'd1);
    check_eq("run_done_clr", 32'(done), 32'd0);
    check_eq("first_no_valid", 32'(out_valid), 32'd0);
    check_eq("start_addr", 32'(rom_addr), 32'(b));
    idx = 0;
    cyc = 0;
    stall = 0;
    while (idx < l && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mid_start && cyc == 2) begin
        start = 1'b1;
        base_addr = 3'($urandom_range(0, 7));
        len = 4'($urandom_range(1, 8));
      end else begin
        start = 1'b0;
      end
      if (mode == 1) check_eq("no_bubble", 32'(out_valid), 32'd1);
      check_eq("busy_hold", 32'(busy), 32'd1);
      check_eq("no_early_done", 32'(done), 32'd0);
      if (mode == 1) begin
        out_ready = 1'b1;
      end else if (mode == 2) begin
        out_ready = !(out_valid && idx == 1 && stall < 3);
        if (!out_ready) stall++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_valid) begin
        exp_word = 32'(rom_mem[(b + idx) % 8]);
        check_eq("beat_data", 32'(out_data), 32'(exp_word));
        check_eq("beat_last", 32'(out_last), (idx == l - 1) ? 32'd1 : 32'd0);
        if (out_ready) idx++;
      end
    end
    start = 1'b0;
    if (cyc >= 100) check_eq("timeout", 32'd0, 32'd1);
    if (mode == 1) check_eq("throughput_cycles", 32'(cyc), 32'(l));
    if (mode == 2) check_eq("stall_cycles", 32'(stall), 32'd3);
    @(negedge clk);
    exp_addr = (b + l) % 8;
    check_eq("end_done", 32'(done), 32'd1);
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_valid", 32'(out_valid), 32'd0);
    check_eq("end_last", 32'(out_last), 32'd0);
    check_eq("end_addr", 32'(rom_addr), 32'(exp_addr));
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_addr = 0;
    for (int i = 0; i < 8; i++) rom_mem[i] = 2'(i % 4);
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 3'd0;
    len = 4'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(2, 3, 1, 1'b0);     // basic: 2,3,0 with last on the third beat
    run_sweep(6, 8, 1, 1'b0);     // full wrap, rom_addr ends at 6
    run_sweep(0, 4, 2, 1'b0);     // backpressure on second beat
    run_sweep(5, 0, 1, 1'b0);     // empty sweep
    run_sweep(3, 5, 1, 1'b1);     // start during RUN ignored
    run_sweep(7, 2, 0, 1'b1);     // back-to-back on the done cycle

    for (int k = 0; k < 25; k++) begin
      run_sweep($urandom_range(0, 7), $urandom_range(0, 8), $urandom_range(0, 1),
                1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // Reset in the middle of a sweep drops the beat and issues no done.
    start = 1'b1;
    base_addr = 3'd1;
    len = 4'd6;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_addr", 32'(rom_addr), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("postrst_done", 32'(done), 32'd0);
      check_eq("postrst_valid", 32'(out_valid), 32'd0);
    end
    exp_addr = 0;
    run_sweep(4, 3, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_sweep_reader.md
# rom_sweep_reader

Sequencer that sits directly upstream of the file-initialised lookup ROM and streams its contents. On a start command it walks a contiguous, wrapping range of ROM addresses, drives the ROM address bus, and captures the asynchronous read data into an output register. It presents each word on a valid/ready stream with a last flag and full backpressure, and pulses done when the sweep completes. Typical use is dumping or replaying truth-table contents into a downstream consumer.

## Interface

Parameters:
- ADDR_WIDTH, 3, ROM address width; ROM depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 2, ROM word width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address of the sweep; sampled with start.
- len  in  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH; sampled with start.
- rom_addr  out  ADDR_WIDTH  address to ROM, registered.
- rom_data  in  DATA_WIDTH  ROM read data, combinational from rom_addr.
- out_data  out  DATA_WIDTH  captured ROM word.
- out_valid  out  1  out_data/out_last valid.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_last  out  1  marks the final beat of the sweep.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at sweep completion.

## Operation

- States: IDLE, RUN.
- Internal state: rom_addr register, remaining counter (ADDR_WIDTH+1 bits).
- IDLE, start=1, len!=0:
  - rom_addr <= base_addr; remaining <= len; go to RUN.
- IDLE, start=1, len=0:
  - Stay in IDLE, pulse done next cycle, emit no beats.
- start in RUN: ignored; base_addr and len are not re-sampled.
- RUN, load condition is remaining!=0 && (!out_valid || out_ready). When it holds:
  - out_data <= rom_data.
  - out_valid <= 1.
  - out_last <= (remaining==1).
  - rom_addr <= rom_addr+1, modulo 2**ADDR_WIDTH (wraps 2**ADDR_WIDTH-1 -> 0).
  - remaining <= remaining-1.
- RUN, remaining==0 and out_valid && out_ready: out_valid <= 0.
- Sweep completion: a handshake with out_last=1 makes the next cycle done=1, state IDLE, busy=0, out_valid=0, out_last=0.
- Backpressure: while out_valid && !out_ready, out_data, out_last, rom_addr and remaining hold unchanged.
- len = 2**ADDR_WIDTH: every address is read exactly once, starting at base_addr and wrapping.
- rom_addr after a sweep: holds base_addr+len (mod depth) in IDLE.

## Timing

- Reset (rst_n=0 at an edge), values after the edge:
  - state=IDLE, rom_addr=0, remaining=0.
  - out_data=0, out_valid=0, out_last=0, busy=0, done=0.
- Reset mid-sweep: same values. The in-flight beat is dropped and no done is issued.
- Latency: start accepted at edge T -> RUN and rom_addr=base_addr after T -> first out_valid after edge T+1.
- Throughput: with out_ready held high, one beat per cycle with no bubbles. An N-word sweep puts its last beat valid after edge T+N.
- done is asserted the cycle after the last handshake. A new start is accepted on the cycle done is high, since state is IDLE then.
- rom_data is treated as combinational from rom_addr and captured in the same cycle; the ROM adds no latency.

## Test plan

Behavioural ROM model: rom[i] = i mod 4, depth 8.

- Reset: assert rst_n=0 mid-sweep -> next cycle out_valid=0, busy=0, rom_addr=0, done=0. No done is issued afterwards.
- Basic sweep: base_addr=2, len=3, out_ready=1.
  - Beats out_data 2,3,0 on consecutive cycles starting 2 cycles after start.
  - out_last=1 only on the third beat.
  - done pulses one cycle later.
- Wrap-around: base_addr=6, len=8.
  - Addresses 6,7,0,...,5 give out_data 2,3,0,1,2,3,0,1.
  - rom_addr ends at 6.
- Backpressure: base_addr=0, len=4, out_ready low for 3 cycles on the second beat.
  - out_data holds at 1 while stalled.
  - Sequence is 0,1,2,3 with no loss or duplication.
- len=0: start -> done=1 next cycle; out_valid and busy stay 0.
- Start during RUN and back-to-back:
  - A start mid-sweep is ignored and beats are unchanged.
  - A start asserted on the done cycle begins a new sweep at its base_addr.
